cell_memory: RTL
================

Name: cell_memory

Overview:
Parametrised single-port word memory for the Lisp machine's cell store; successor to the fixed 256x16 read-only request/ready memory. Adds writes, a configurable read latency, busy back-pressure, out-of-range error reporting and synchronous reset. It sits between the evaluator/allocator FSMs and block RAM, and serves one outstanding request at a time.

Parameters:
DATA_WIDTH, 16, width of one memory word (cell half / tagged pointer)
ADDR_WIDTH, 12, width of addr_in
DEPTH, 256, number of implemented words; must be <= 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from request accept to data_ready; legal range 1..4

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
req  input  1  one-cycle request strobe; sampled only when busy=0
we  input  1  1 = write, 0 = read; qualified by req
addr_in  input  ADDR_WIDTH  word address; qualified by req
data_in  input  DATA_WIDTH  write data; qualified by req & we
busy  output  1  request in flight; req ignored while high
data_ready  output  1  one-cycle completion pulse for read or write
data_out  output  DATA_WIDTH  read data; valid when data_ready=1 and we of that request was 0
err  output  1  qualifies data_ready: request address was >= DEPTH

Behaviour:
- Reset (rst=1 at posedge): state IDLE; busy=0, data_ready=0, err=0, data_out=0. Any in-flight request is dropped with no data_ready. A req in the same cycle as rst is ignored. Memory contents are untouched; see the optional feature.
- Storage: DEPTH x DATA_WIDTH array, block-RAM inferred. Power-up contents: word 0 = 0 (NIL), word 1 = 16'hBEEF truncated or zero-extended to DATA_WIDTH, all others 0.
- FSM: IDLE -> WAIT on accept. WAIT counts READ_LATENCY-1 cycles -> RESP. RESP -> IDLE after one cycle.
- Accept: cycle T with state IDLE, rst=0 and req=1. The block latches we, addr_in and data_in.
  - Write with addr_in < DEPTH: mem[addr_in] <= data_in at the end of cycle T.
- busy=1 in cycles T+1 .. T+READ_LATENCY. Equivalently, busy = (state != IDLE).
- data_ready=1 for exactly one cycle, T+READ_LATENCY; err is valid in the same cycle.
- The earliest next accept is cycle T+READ_LATENCY+1. A req while busy=1 is dropped, not queued.
- Read: data_out = mem[addr] as of the accept cycle. data_out holds its value until the next read completion or reset.
- Write: data_ready pulse acts as an acknowledge; data_out is unchanged.
- Out of range (addr_in >= DEPTH): no array access and no write. The request completes with normal latency: data_ready=1, err=1. On a read, data_out=0. On a write, data_out is unchanged.
- err=0 whenever data_ready=0.
- Read-after-write: a read accepted after a write's data_ready returns the written value.
- Address compare is unsigned and full ADDR_WIDTH. There is no wrap-around or aliasing onto valid words.

Optional Feature:
CELL_MEMORY_CLEAR_EN.
- Defined: every reset starts a CLEAR state after rst deasserts.
  - Writes 0 to addresses 0..DEPTH-1, one per cycle, over DEPTH cycles.
  - busy=1 throughout; req is ignored; data_ready stays 0.
  - Then enters IDLE.
  - rst asserted mid-clear restarts the sweep from address 0.
- Undefined: no CLEAR state. Contents persist across reset and keep their power-up values until written.

Test Plan:
- READ_LATENCY=1, power-up, read addr 1 -> data_ready at T+1, data_out=16'hBEEF, err=0, busy high only in T+1.
- READ_LATENCY=3: write 16'h1234 to addr 5, wait for ack, read addr 5 -> data_ready at T+3 with data_out=16'h1234; busy high T+1..T+3.
- Read addr 300 with DEPTH=256 -> data_ready=1, err=1, data_out=0. A write to addr 300 -> err=1, and a read of addr 44 (300 mod 256) afterwards still returns 0.
- req pulsed again at T+1 while busy -> ignored; only one data_ready. A req at T+READ_LATENCY+1 is accepted.
- rst at T+1 of a READ_LATENCY=3 read -> no data_ready, all outputs 0 the next cycle, and the memory still holds the prior write.
- CELL_MEMORY_CLEAR_EN, DEPTH=16: write 16'hFFFF to addr 3, then reset -> busy for 16 cycles, req ignored; afterwards a read of addr 3 returns 0 and a read of addr 1 returns 0.

Source files
------------

// File: rtl/cell_memory.sv
// rtl/cell_memory.sv - single-port cell store with latency, back-pressure and range errors
// Optional reset-time sweep of the array is enabled by defining CELL_MEMORY_CLEAR_EN.
module cell_memory #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 12,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  data_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  err
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] BEEF_WORD = DATA_WIDTH'(16'hBEEF);
    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, CLEAR} state_t;

    state_t                state;
    logic [1:0]            lat_cnt;
    logic                  we_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] out_hold;
    logic [DATA_WIDTH-1:0] rd_value;
    logic                  accept;
    logic                  in_range;
    logic                  mem_we;
    logic [MEM_AW-1:0]     mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
`ifdef CELL_MEMORY_CLEAR_EN
    logic [MEM_AW-1:0]     clr_addr;
`endif

    // Power-up image: word 1 carries the BEEF marker, everything else is NIL.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{1: BEEF_WORD, default: '0};

    assign in_range = ({1'b0, addr_in} < DEPTH_A);
    assign accept   = !rst && (state == IDLE) && req;
    assign rd_value = err_q ? '0 : ram_q;
    assign data_out = (data_ready && !we_q) ? rd_value : out_hold;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_in[MEM_AW-1:0];
        mem_wdata = data_in;
        if (accept && we && in_range) begin
            mem_we = 1'b1;
        end
`ifdef CELL_MEMORY_CLEAR_EN
        if (!rst && (state == CLEAR)) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end
`endif
    end

    // Single write port plus registered read port so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (accept && !we && in_range) begin
            ram_q <= mem[addr_in[MEM_AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef CELL_MEMORY_CLEAR_EN
            state    <= CLEAR;
            busy     <= 1'b1;
            clr_addr <= '0;
`else
            state    <= IDLE;
            busy     <= 1'b0;
`endif
            data_ready <= 1'b0;
            err        <= 1'b0;
            out_hold   <= '0;
            lat_cnt    <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q  <= we;
                        err_q <= !in_range;
                        busy  <= 1'b1;
                        if (READ_LATENCY == 1) begin
                            state      <= RESP;
                            data_ready <= 1'b1;
                            err        <= !in_range;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == WAIT_LAST) begin
                        state      <= RESP;
                        data_ready <= 1'b1;
                        err        <= err_q;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!we_q) begin
                        out_hold <= rd_value;
                    end
                end
`ifdef CELL_MEMORY_CLEAR_EN
                CLEAR: begin
                    if (clr_addr == MEM_AW'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
